// File: rtl/uart_baud_gen.sv
// UART baud-tick generator: fractional divisor yields oversample, bit and mid-bit ticks,
// with a run-time divisor shadow and an RX realign strobe that restarts the tick phase.
module uart_baud_gen #(
  parameter int unsigned     CLK_HZ       = 100_000_000,
  parameter int unsigned     BAUD_DEFAULT = 9600,
  parameter int unsigned     OVERSAMPLE   = 16,
  parameter int unsigned     DIV_W        = 16,
  parameter int unsigned     FRAC_W       = 4,
  parameter longint unsigned DEFAULT_DIV  =
    (64'(CLK_HZ) * (64'd1 << FRAC_W) + (64'(BAUD_DEFAULT) * 64'(OVERSAMPLE)) / 64'd2)
    / (64'(BAUD_DEFAULT) * 64'(OVERSAMPLE))
) (
  input  logic                          clkin,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          cfg_wr,
  input  logic [DIV_W+FRAC_W-1:0]       cfg_div,
  input  logic                          rx_realign,
  output logic                          os_tick,
  output logic                          bit_tick,
  output logic                          mid_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

  localparam int unsigned CFG_W = DIV_W + FRAC_W;
  localparam int unsigned PH_W  = $clog2(OVERSAMPLE);

  typedef logic [DIV_W:0]   cnt_t;
  typedef logic [CFG_W-1:0] div_t;

  localparam div_t             RST_DIV = CFG_W'(DEFAULT_DIV);
  localparam logic [PH_W-1:0]  MID_PH  = PH_W'(OVERSAMPLE / 2);

  // Integer part of a divisor, clamped so a period is never shorter than 2 cycles.
  function automatic cnt_t eff_int(input div_t div);
    logic [DIV_W-1:0] di;
    di = div[CFG_W-1:FRAC_W];
    if (di < DIV_W'(2)) return cnt_t'(2);
    return {1'b0, di};
  endfunction

  cnt_t             cnt_q, cnt_d;
  cnt_t             period_q, period_d;
  logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  div_t             active_q, active_d;
  div_t             shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             os_tick_q, os_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             mid_tick_q, mid_tick_d;

  logic             wrap;
  div_t             upd_div;
  logic [FRAC_W:0]  frac_sum;
  logic [PH_W-1:0]  phase_inc;

  assign wrap      = (cnt_q == period_q - cnt_t'(1));
  assign upd_div   = pend_q ? shadow_q : active_q;
  assign frac_sum  = {1'b0, frac_acc_q} + {1'b0, upd_div[FRAC_W-1:0]};
  assign phase_inc = phase_q + PH_W'(1);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    cnt_d      = cnt_q;
    period_d   = period_q;
    frac_acc_d = frac_acc_q;
    phase_d    = phase_q;
    active_d   = active_q;
    shadow_d   = shadow_q;
    pend_d     = pend_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;

    if (rx_realign) begin
      active_d   = cfg_wr ? cfg_div : upd_div;
      shadow_d   = active_d;
      pend_d     = 1'b0;
      cnt_d      = '0;
      frac_acc_d = '0;
      phase_d    = '0;
      period_d   = eff_int(active_d);
    end else begin
      if (cfg_wr) begin
        shadow_d = cfg_div;
        pend_d   = 1'b1;
      end
      if (en && wrap) begin
        // The divisor for the coming period (new one if pending) also drives the carry.
        cnt_d      = '0;
        frac_acc_d = frac_sum[FRAC_W-1:0];
        period_d   = eff_int(upd_div) + cnt_t'(frac_sum[FRAC_W]);
        phase_d    = phase_inc;
        os_tick_d  = 1'b1;
        bit_tick_d = (phase_inc == '0);
        mid_tick_d = (phase_inc == MID_PH);
        active_d   = upd_div;
        if (!cfg_wr) pend_d = 1'b0;
      end else if (en) begin
        cnt_d = cnt_q + cnt_t'(1);
      end else if (pend_q) begin
        active_d = shadow_q;
        if (!cfg_wr) pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      period_q   <= eff_int(RST_DIV);
      frac_acc_q <= '0;
      phase_q    <= '0;
      active_q   <= RST_DIV;
      shadow_q   <= RST_DIV;
      pend_q     <= 1'b0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      frac_acc_q <= frac_acc_d;
      phase_q    <= phase_d;
      active_q   <= active_d;
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
    end
  end

  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;
  assign mid_tick = mid_tick_q;
  assign os_phase = phase_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen at default parameters (divisor 651 + 1/16, 16x oversample).
module tb_uart_baud_gen;

  logic        clkin      = 1'b0;
  logic        rst_n      = 1'b1;
  logic        en         = 1'b0;
  logic        cfg_wr     = 1'b0;
  logic        rx_realign = 1'b0;
  logic [19:0] cfg_div    = '0;
  logic        os_tick, bit_tick, mid_tick;
  logic [3:0]  os_phase;

  int checks = 0;
  int errors = 0;

  always #5 clkin = ~clkin;

  uart_baud_gen dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .en         (en),
    .cfg_wr     (cfg_wr),
    .cfg_div    (cfg_div),
    .rx_realign (rx_realign),
    .os_tick    (os_tick),
    .bit_tick   (bit_tick),
    .mid_tick   (mid_tick),
    .os_phase   (os_phase)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  // Edges stepped until os_tick is seen; -1 on timeout.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (os_tick !== 1'b1 && n < 20000);
    if (os_tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no os_tick within %0d cycles", n);
      n = -1;
    end
  endtask

  task automatic pulse_realign();
    rx_realign = 1'b1;
    step();
    rx_realign = 1'b0;
  endtask

  task automatic load(input logic [19:0] d, input logic realign);
    cfg_div    = d;
    cfg_wr     = 1'b1;
    rx_realign = realign;
    step();
    cfg_wr     = 1'b0;
    rx_realign = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sum;
    int seen;

    #2 rst_n = 1'b0;
    repeat (3) step();
    check("rst_os_tick", os_tick, 0);
    check("rst_bit_tick", bit_tick, 0);
    check("rst_mid_tick", mid_tick, 0);
    check("rst_os_phase", os_phase, 0);
    rst_n = 1'b1;
    en    = 1'b1;

    // Defaults: 16 periods of 651, then a 652 as the fraction carries.
    wait_tick(n);
    check("t1_first_period", n, 651);
    check("t1_phase_after_1", os_phase, 1);
    check("t1_no_bit_at_1", bit_tick, 0);
    sum = n;
    for (int k = 2; k <= 16; k++) begin
      wait_tick(n);
      sum += n;
      if (k == 8) begin
        check("t1_mid_at_8", mid_tick, 1);
        check("t1_phase_at_8", os_phase, 8);
      end
    end
    check("t1_bit_at_16", bit_tick, 1);
    check("t1_phase_wrap", os_phase, 0);
    check("t1_span_1_16", sum, 10416);
    sum = 0;
    for (int k = 17; k <= 32; k++) begin
      wait_tick(n);
      sum += n;
      if (k == 17) check("t1_period_17", n, 652);
      if (k == 24) check("t1_mid_at_24", mid_tick, 1);
    end
    check("t1_bit_at_32", bit_tick, 1);
    check("t1_bit_period", sum, 10417);

    // Realign cancels a tick due on the same edge.
    pulse_realign();
    check("ra_phase_zero", os_phase, 0);
    wait_tick(n);
    check("ra_first_period", n, 651);
    repeat (650) step();
    pulse_realign();
    check("ra_override_no_tick", os_tick, 0);
    wait_tick(n);
    check("ra_after_override", n, 651);

    // Realign 300 cycles into a period at os_phase 5.
    for (int k = 0; k < 4; k++) wait_tick(n);
    check("ra_phase_5", os_phase, 5);
    repeat (299) step();
    pulse_realign();
    check("ra_mid_phase_zero", os_phase, 0);
    check("ra_mid_no_tick", os_tick, 0);
    wait_tick(n);
    check("ra_next_tick", n, 651);
    for (int k = 2; k <= 8; k++) wait_tick(n);
    check("ra_mid_at_8th", mid_tick, 1);

    // en low for 1000 cycles at cnt=400.
    pulse_realign();
    wait_tick(n);
    check("en_pre_period", n, 651);
    repeat (400) step();
    en   = 1'b0;
    seen = 0;
    repeat (1000) begin
      step();
      if (os_tick || bit_tick || mid_tick) seen++;
    end
    check("en_no_ticks", seen, 0);
    check("en_phase_hold", os_phase, 1);
    en = 1'b1;
    wait_tick(n);
    check("en_resume_period", n, 251);
    check("en_phase_after", os_phase, 2);

    // cfg_wr 54.5 mid-period: old period completes, then 54/55 alternate.
    pulse_realign();
    repeat (100) step();
    load(20'h00368, 1'b0);
    wait_tick(n);
    check("cfg_old_period_done", n, 550);
    sum = 0;
    for (int k = 0; k < 16; k++) begin
      wait_tick(n);
      sum += n;
      if (k == 0) check("cfg_period_a", n, 54);
      if (k == 1) check("cfg_period_b", n, 55);
    end
    check("cfg_span_16", sum, 872);

    // Clamp of div_int below 2, loaded together with realign.
    load(20'h00010, 1'b1);
    wait_tick(n);
    check("clamp1_first", n, 2);
    wait_tick(n);
    check("clamp1_second", n, 2);
    load(20'h00000, 1'b1);
    wait_tick(n);
    check("clamp0_first", n, 2);
    wait_tick(n);
    check("clamp0_second", n, 2);
    load(20'h00368, 1'b1);
    wait_tick(n);
    check("cfg_with_realign", n, 54);

    // Reset while os_tick is high, then defaults restart.
    wait_tick(n);
    rst_n = 1'b0;
    #1;
    check("rst_mid_os_tick", os_tick, 0);
    check("rst_mid_bit_tick", bit_tick, 0);
    check("rst_mid_mid_tick", mid_tick, 0);
    check("rst_mid_os_phase", os_phase, 0);
    repeat (2) step();
    rst_n = 1'b1;
    wait_tick(n);
    check("rst_restart_period", n, 651);
    check("rst_restart_phase", os_phase, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
